// File: rtl/raybox_column_renderer.sv
// Ping-pong column renderer for raybox: the tracer fills the back trace bank while the VGA beam
// reads the front bank; banks swap at VBLANK start once the tracer has committed a full frame.
module raybox_column_renderer #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int HEIGHT_BITS = 8,
  parameter int COLOR_BITS  = 2,
  parameter int FAR_HEIGHT  = 60
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             h,
  input  logic [9:0]             v,
  input  logic                   visible,
  input  logic                   shade_en,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [9:0]             wr_col,
  input  logic                   wr_side,
  input  logic [HEIGHT_BITS-1:0] wr_height,
  input  logic                   wr_commit,
  output logic [COLOR_BITS-1:0]  red,
  output logic [COLOR_BITS-1:0]  green,
  output logic [COLOR_BITS-1:0]  blue,
  output logic                   pix_visible,
  output logic [7:0]             dropped,
  output logic                   wr_err
);

  localparam int HALF = V_RES / 2;
  localparam int HMAX = (1 << HEIGHT_BITS) - 1;
  localparam logic [10:0] HALF_W   = 11'(HALF);
  localparam logic [10:0] FAR_W    = 11'(FAR_HEIGHT);
  localparam logic [10:0] H_RES_W  = 11'(H_RES);
  localparam logic [9:0]  VBL_LINE = 10'(V_RES);
  localparam logic [HEIGHT_BITS-1:0] CLAMP_H = HEIGHT_BITS'((HALF < HMAX) ? HALF : HMAX);
  localparam logic [COLOR_BITS-1:0]  C_MAX   = {COLOR_BITS{1'b1}};
  localparam logic [COLOR_BITS-1:0]  C_CEIL  = COLOR_BITS'(1);
  localparam logic [COLOR_BITS-1:0]  C_FLOOR = (COLOR_BITS == 1) ? C_MAX : COLOR_BITS'(2);

  typedef enum logic {FILL = 1'b0, LOCKED = 1'b1} state_t;

  state_t state;
  logic   front_sel, front_valid;
  logic   vblank_start, wr_fire, col_ok;
  logic [HEIGHT_BITS-1:0] wr_h_clamped;

  // Each entry is {side, half_height}; bank[front_sel] is displayed, the other is filled.
  logic [HEIGHT_BITS:0] bank0 [H_RES];
  logic [HEIGHT_BITS:0] bank1 [H_RES];
  logic [HEIGHT_BITS:0] rd_q;

  logic       h_ok_q, vis_q, fv_q, shade_q;
  logic [9:0] v_q;

  // Write handshake: an entry transfers on any clk edge where wr_valid && wr_ready; wr_ready
  // depends only on renderer state (never on wr_valid) and wr_commit is taken whenever wr_ready=1.
  assign vblank_start = (v == VBL_LINE) && (h == 10'd0);
  assign wr_ready     = reset && (state == FILL) && !vblank_start;
  assign wr_fire      = wr_valid && wr_ready;
  assign col_ok       = {1'b0, wr_col} < H_RES_W;
  assign wr_h_clamped = (wr_height > CLAMP_H) ? CLAMP_H : wr_height;

  always_ff @(posedge clk) begin
    if (wr_fire && col_ok) begin
      if (front_sel) bank0[wr_col] <= {wr_side, wr_h_clamped};
      else           bank1[wr_col] <= {wr_side, wr_h_clamped};
    end
    rd_q <= front_sel ? bank1[h] : bank0[h];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FILL;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      dropped     <= 8'd0;
      wr_err      <= 1'b0;
    end else begin
      if (wr_fire && !col_ok) wr_err <= 1'b1;
      case (state)
        FILL: begin
          // wr_ready is low during vblank_start, so a commit can never coincide with a drop.
          if (vblank_start)              dropped <= dropped + 8'd1;
          else if (wr_ready && wr_commit) state  <= LOCKED;
        end
        LOCKED: begin
          if (vblank_start) begin
            state       <= FILL;
            front_sel   <= ~front_sel;
            front_valid <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_ok_q  <= 1'b0;
      vis_q   <= 1'b0;
      fv_q    <= 1'b0;
      shade_q <= 1'b0;
      v_q     <= 10'd0;
    end else begin
      h_ok_q  <= {1'b0, h} < H_RES_W;
      vis_q   <= visible;
      fv_q    <= front_valid;
      shade_q <= shade_en;
      v_q     <= v;
    end
  end

  logic [HEIGHT_BITS-1:0] ht_s;
  logic                   side_s, in_wall;
  logic [10:0]            ht_w, v_w;
  logic [COLOR_BITS-1:0]  wall_b;

  always_comb begin
    ht_s    = (fv_q && h_ok_q) ? rd_q[HEIGHT_BITS-1:0] : '0;
    side_s  = rd_q[HEIGHT_BITS];
    ht_w    = 11'(ht_s);
    v_w     = {1'b0, v_q};
    // v >= HALF-height rewritten as v+height >= HALF to avoid underflow.
    in_wall = (v_w + ht_w >= HALF_W) && (v_w < HALF_W + ht_w);
    wall_b  = side_s ? C_MAX : C_MAX - C_CEIL;
    if (shade_q && (ht_w < FAR_W) && (wall_b > C_CEIL)) wall_b = wall_b - C_CEIL;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pix_visible <= 1'b0;
    end else begin
      pix_visible <= vis_q;
      if (!vis_q) begin
        red <= '0; green <= '0; blue <= '0;
      end else if (in_wall) begin
        red <= '0; green <= '0; blue <= wall_b;
      end else if (v_w < HALF_W) begin
        red <= C_CEIL; green <= C_CEIL; blue <= C_CEIL;
      end else begin
        red <= C_FLOOR; green <= C_FLOOR; blue <= C_FLOOR;
      end
    end
  end

endmodule

// File: tb/tb_raybox_column_renderer.sv
// Bench for raybox_column_renderer: constant vector tables for the fixed scenes plus a randomized
// phase checked against a frame-level model of the two trace banks and swap rules.
module tb_raybox_column_renderer;

  localparam int H_RES = 640;
  localparam int HALF  = 240;
  localparam int NV    = 17;

  logic       clk, reset;
  logic [9:0] h, v;
  logic       visible, shade_en, wr_valid, wr_ready, wr_side, wr_commit;
  logic [9:0] wr_col;
  logic [7:0] wr_height;
  logic [1:0] red, green, blue;
  logic       pix_visible, wr_err;
  logic [7:0] dropped;

  raybox_column_renderer dut (
    .clk(clk), .reset(reset), .h(h), .v(v), .visible(visible), .shade_en(shade_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_side(wr_side),
    .wr_height(wr_height), .wr_commit(wr_commit), .red(red), .green(green), .blue(blue),
    .pix_visible(pix_visible), .dropped(dropped), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int h; int v; bit vis; bit sh; logic [5:0] pix; string nm; } vec_t;

  vec_t       tbl [NV];
  logic [6:0] exp_q [$];
  string      nm_q [$];
  int         errors = 0;
  int         checks = 0;

  // Frame-level model: two banks of {side, clamped height}, which one is shown, and swap state.
  int m_h [2][H_RES];
  bit m_s [2][H_RES];
  int m_front, m_dropped;
  bit m_valid, m_committed, m_err;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int hh, input int vv, input bit vis, input bit sh,
                              input int r, input int g, input int b, input string nm);
    vec_t t;
    t.h = hh; t.v = vv; t.vis = vis; t.sh = sh; t.nm = nm;
    t.pix = {2'(r), 2'(g), 2'(b)};
    return t;
  endfunction

  function automatic logic [6:0] model_pix(input int hh, input int vv, input bit vis, input bit sh);
    int ht, b;
    bit sd;
    if (!vis) return 7'd0;
    ht = 0; sd = 0;
    if (m_valid && hh < H_RES) begin
      ht = m_h[m_front][hh];
      sd = m_s[m_front][hh];
    end
    if (ht > 0 && vv >= HALF - ht && vv < HALF + ht) begin
      b = sd ? 3 : 2;
      if (sh && ht < 60 && b > 1) b = b - 1;
      return {1'b1, 2'd0, 2'd0, 2'(b)};
    end
    if (vv < HALF) return {1'b1, 2'd1, 2'd1, 2'd1};
    return {1'b1, 2'd2, 2'd2, 2'd2};
  endfunction

  // One clock: predict pixel and handshake, advance the model, then check after the edge.
  task automatic cycle(input string nm, input bit use_tbl, input logic [5:0] tpix);
    logic [6:0] e, got;
    bit rdy, vbl;
    string pn;
    #1;
    e = model_pix(int'(h), int'(v), visible, shade_en);
    if (use_tbl) e = {visible, tpix};
    exp_q.push_back(e);
    nm_q.push_back(nm);
    vbl = (int'(v) == 480) && (h == 10'd0);
    rdy = !m_committed && !vbl;
    check({nm, "/wr_ready"}, int'(wr_ready), int'(rdy));
    if (rdy && wr_valid) begin
      if (int'(wr_col) < H_RES) begin
        m_h[1 - m_front][int'(wr_col)] = (int'(wr_height) > HALF) ? HALF : int'(wr_height);
        m_s[1 - m_front][int'(wr_col)] = wr_side;
      end else m_err = 1'b1;
    end
    if (rdy && wr_commit) m_committed = 1'b1;
    if (vbl) begin
      if (m_committed) begin
        m_front = 1 - m_front; m_valid = 1'b1; m_committed = 1'b0;
      end else m_dropped = (m_dropped + 1) % 256;
    end
    @(posedge clk);
    #1;
    check({nm, "/dropped"}, int'(dropped), m_dropped);
    check({nm, "/wr_err"}, int'(wr_err), int'(m_err));
    if (exp_q.size() >= 2) begin
      e  = exp_q.pop_front();
      pn = nm_q.pop_front();
      got = {pix_visible, red, green, blue};
      check({pn, "/pixel"}, int'(got), int'(e));
    end
  endtask

  task automatic idle();
    h = 10'd0; v = 10'd0; visible = 1'b0; wr_valid = 1'b0; wr_commit = 1'b0;
  endtask

  task automatic write(input int col, input bit side, input int hgt, input bit cm, input string nm);
    wr_valid = 1'b1; wr_col = 10'(col); wr_side = side; wr_height = 8'(hgt); wr_commit = cm;
    cycle(nm, 1'b0, 6'd0);
    wr_valid = 1'b0; wr_commit = 1'b0;
  endtask

  task automatic vblank();
    h = 10'd0; v = 10'd480; visible = 1'b0;
    cycle("vblank", 1'b0, 6'd0);
    v = 10'd0;
  endtask

  task automatic flush();
    idle();
    cycle("flush", 1'b0, 6'd0);
    cycle("flush", 1'b0, 6'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle();
    exp_q.delete(); nm_q.delete();
    m_front = 0; m_valid = 0; m_committed = 0; m_dropped = 0; m_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/colour", int'({red, green, blue}), 0);
    check("rst/pix_visible", int'(pix_visible), 0);
    check("rst/dropped", int'(dropped), 0);
    check("rst/wr_err", int'(wr_err), 0);
    check("rst/wr_ready", int'(wr_ready), 0);
    reset = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < NV; i++) begin
      h = 10'(tbl[i].h); v = 10'(tbl[i].v); visible = tbl[i].vis; shade_en = tbl[i].sh;
      cycle({tag, "_", tbl[i].nm}, 1'b1, tbl[i].pix);
    end
    flush();
  endtask

  task automatic rand_step();
    int col;
    if ($urandom_range(0, 99) < 2) begin
      vblank();
      return;
    end
    visible  = ($urandom_range(0, 3) != 0);
    h        = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom_range(0, 639));
    v        = 10'($urandom_range(0, 479));
    shade_en = 1'($urandom_range(0, 1));
    col      = ($urandom_range(0, 19) == 0) ? 640 + $urandom_range(0, 383) : $urandom_range(0, 31);
    wr_valid = 1'($urandom_range(0, 1));
    wr_col   = 10'(col);
    wr_side  = 1'($urandom_range(0, 1));
    wr_height = 8'($urandom_range(0, 255));
    wr_commit = ($urandom_range(0, 29) == 0);
    cycle("rand", 1'b0, 6'd0);
    wr_valid = 1'b0; wr_commit = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    tbl[0]  = mk(100, 199, 1, 0, 1, 1, 1, "c100_v199");
    tbl[1]  = mk(100, 200, 1, 0, 0, 0, 3, "c100_v200");
    tbl[2]  = mk(100, 279, 1, 0, 0, 0, 3, "c100_v279");
    tbl[3]  = mk(100, 280, 1, 0, 2, 2, 2, "c100_v280");
    tbl[4]  = mk(100, 239, 1, 0, 0, 0, 3, "c100_v239");
    tbl[5]  = mk(101, 250, 1, 0, 2, 2, 2, "c101_v250");
    tbl[6]  = mk(5,   0,   1, 0, 0, 0, 2, "c5_v0");
    tbl[7]  = mk(5,   479, 1, 0, 0, 0, 2, "c5_v479");
    tbl[8]  = mk(30,  239, 1, 1, 0, 0, 1, "c30_shade");
    tbl[9]  = mk(30,  239, 1, 0, 0, 0, 2, "c30_noshade");
    tbl[10] = mk(100, 250, 1, 1, 0, 0, 2, "c100_shade");
    tbl[11] = mk(5,   100, 1, 1, 0, 0, 2, "c5_shade_near");
    tbl[12] = mk(31,  100, 1, 0, 1, 1, 1, "c31_ceiling");
    tbl[13] = mk(100, 250, 0, 0, 0, 0, 0, "c100_blank");
    tbl[14] = mk(30,  209, 1, 1, 1, 1, 1, "c30_v209");
    tbl[15] = mk(30,  269, 1, 1, 0, 0, 1, "c30_v269");
    tbl[16] = mk(30,  270, 1, 0, 2, 2, 2, "c30_v270");

    shade_en = 1'b0; wr_col = 10'd0; wr_side = 1'b0; wr_height = 8'd0;
    apply_reset();

    // Empty frame: background only, then a swap attempt with nothing committed.
    for (int i = 0; i < 20; i++) begin
      visible = 1'b1; h = 10'($urandom_range(0, 639)); v = 10'($urandom_range(0, 479));
      shade_en = 1'($urandom_range(0, 1));
      cycle("empty_frame", 1'b0, 6'd0);
    end
    vblank();
    check("dropped_first", int'(dropped), 1);

    // Define both banks everywhere, then load the test scene with commit on the last write.
    for (int c = 0; c < H_RES; c++) write(c, 1'b0, 0, (c == H_RES - 1), "init_a");
    vblank();
    for (int c = 0; c < H_RES; c++) write(c, 1'b0, 0, 1'b0, "init_b");
    write(100, 1'b1, 40, 1'b0, "col100");
    write(5, 1'b0, 255, 1'b0, "col5_clamp");
    write(30, 1'b0, 30, 1'b1, "col30_commit");
    check("ready_after_commit", int'(wr_ready), 0);
    write(100, 1'b1, 10, 1'b0, "locked_write");
    write(200, 1'b1, 50, 1'b1, "locked_commit");
    vblank();
    run_table("scene");

    check("err_before", int'(wr_err), 0);
    write(700, 1'b1, 100, 1'b0, "col700");
    check("err_set", int'(wr_err), 1);

    // Partial back-bank data and three frames without commit: image must not change.
    write(100, 1'b0, 5, 1'b0, "partial");
    d0 = m_dropped;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 10; i++) begin
        visible = 1'b1; h = 10'($urandom_range(95, 105)); v = 10'($urandom_range(0, 479));
        cycle("repeat_frame", 1'b0, 6'd0);
      end
      vblank();
    end
    check("dropped_plus3", int'(dropped), (d0 + 3) % 256);
    run_table("repeat");

    repeat (3000) rand_step();
    flush();

    // Reset after a commit: the commit is forgotten and the next swap is dropped.
    vblank();
    write(3, 1'b1, 100, 1'b1, "pre_reset_commit");
    apply_reset();
    vblank();
    check("dropped_after_reset", int'(dropped), 1);
    h = 10'd3; v = 10'd240; visible = 1'b1; shade_en = 1'b0;
    cycle("after_reset_bg", 1'b1, 6'b101010);
    h = 10'd3; v = 10'd100;
    cycle("after_reset_ceil", 1'b1, 6'b010101);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
